// File: rtl/flash_spi_pkg.sv
// Shared types and constants for the management-flash SPI read path.
// The FSM state encoding is exported so checkers can bind to it.
package flash_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_DESEL
  } state_t;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 32;

  // Flash bytes arrive first-byte-first in the shift register; the core wants little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_spi_sck_gen.sv
// SCK generator: CLK_DIV clk cycles per half-period, low half first.
// Strobes mark the clk edge on which SCK is about to rise or fall.
module flash_spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          half_end;

  assign half_end = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_stb = half_end && !sck;
  assign fall_stb = half_end && sck;

  always_ff @(posedge clk) begin
    if (!resetn || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/flash_spi_reader.sv
// Single-word 0x03 READ initiator for the management flash pads (mode 0, MSB first).
// Keeps CSB low after a read so an address-sequential request skips the command/address preamble.
module flash_spi_reader
  import flash_spi_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int CS_IDLE      = 2,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  // Request handshake: a request transfers on any cycle where req_valid && req_ready;
  // req_valid must hold with stable req_addr until then. rsp_valid is a one-cycle pulse
  // with no backpressure and rsp_data holds until the next pulse.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        flash_csb_core,
  output logic        flash_clk_core,
  output logic        flash_csb_oe_core,
  output logic        flash_clk_oe_core,
  output logic        flash_io0_oe_core,
  output logic        flash_io1_oe_core,
  output logic        flash_io0_ie_core,
  output logic        flash_io1_ie_core,
  output logic        flash_io0_do_core,
  output logic        flash_io1_do_core,
  input  logic        flash_io0_di_core,
  input  logic        flash_io1_di_core,
  output state_t      dbg_state
);

  localparam int HW         = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int DW         = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam int HOLD_LOAD  = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;
  localparam int DESEL_LOAD = (CS_IDLE > 0) ? CS_IDLE - 1 : 0;

  state_t        state;
  logic [4:0]    bit_cnt;
  logic [31:0]   tx_sr;
  logic [31:0]   rx_sr;
  logic [23:0]   last_addr;
  logic [23:0]   pend_addr;
  logic          pend;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] desel_cnt;

  logic          sck_en;
  logic          rise_stb;
  logic          fall_stb;
  logic          accept;
  logic          seq_hit;
  logic          start_fresh;
  logic [23:0]   start_addr;
  logic          unused_io0_di;

  assign flash_csb_oe_core = 1'b1;
  assign flash_clk_oe_core = 1'b1;
  assign flash_io0_oe_core = 1'b1;
  assign flash_io1_oe_core = 1'b0;
  assign flash_io0_ie_core = 1'b0;
  assign flash_io1_ie_core = 1'b1;
  assign flash_io1_do_core = 1'b0;
  assign unused_io0_di     = flash_io0_di_core;
  assign dbg_state         = state;

  assign sck_en  = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
  assign accept  = req_valid && req_ready;
  // 25-bit compare so 0xFFFFFC + 4 never aliases onto 0x000000.
  assign seq_hit = (({1'b0, last_addr} + 25'd4) == {1'b0, req_addr});

  assign start_fresh = ((state == ST_IDLE) && accept) ||
                       ((state == ST_DESEL) && (desel_cnt == '0) && pend);
  assign start_addr  = (state == ST_IDLE) ? req_addr : pend_addr;

  flash_spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .resetn   (resetn),
    .en       (sck_en),
    .sck      (flash_clk_core),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= ST_DESEL;
      desel_cnt         <= DW'(DESEL_LOAD);
      hold_cnt          <= '0;
      bit_cnt           <= '0;
      tx_sr             <= '0;
      rx_sr             <= '0;
      last_addr         <= '0;
      pend_addr         <= '0;
      pend              <= 1'b0;
      req_ready         <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      flash_csb_core    <= 1'b1;
      flash_io0_do_core <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: ;  // accept handled by start_fresh below

        ST_CMD, ST_ADDR: begin
          if (fall_stb) begin
            flash_io0_do_core <= tx_sr[31];
            tx_sr             <= {tx_sr[30:0], 1'b0};
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 5'd1;
            end else if (state == ST_CMD) begin
              state   <= ST_ADDR;
              bit_cnt <= 5'(ADDR_BITS - 1);
            end else begin
              state   <= ST_DATA;
              bit_cnt <= 5'(DATA_BITS - 1);
            end
          end
        end

        ST_DATA: begin
          if (rise_stb) rx_sr <= {rx_sr[30:0], flash_io1_di_core};
          if (fall_stb) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 5'd1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_data  <= byte_swap(rx_sr);
              if (HOLD_TIMEOUT > 0) begin
                state     <= ST_HOLD;
                hold_cnt  <= HW'(HOLD_LOAD);
                req_ready <= 1'b1;
              end else begin
                state          <= ST_DESEL;
                desel_cnt      <= DW'(DESEL_LOAD);
                flash_csb_core <= 1'b1;
              end
            end
          end
        end

        ST_HOLD: begin
          // A request on the expiry cycle still wins over the timeout.
          if (accept) begin
            req_ready <= 1'b0;
            if (seq_hit) begin
              state     <= ST_DATA;
              bit_cnt   <= 5'(DATA_BITS - 1);
              last_addr <= req_addr;
            end else begin
              state          <= ST_DESEL;
              desel_cnt      <= DW'(DESEL_LOAD);
              flash_csb_core <= 1'b1;
              pend           <= 1'b1;
              pend_addr      <= req_addr;
            end
          end else if (hold_cnt == '0) begin
            state          <= ST_DESEL;
            desel_cnt      <= DW'(DESEL_LOAD);
            flash_csb_core <= 1'b1;
            req_ready      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end

        ST_DESEL: begin
          if (desel_cnt != '0) begin
            desel_cnt <= desel_cnt - DW'(1);
          end else if (pend) begin
            pend <= 1'b0;
          end else begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end

        default: state <= ST_DESEL;
      endcase

      // Launch a fresh transaction: first command bit goes out with CSB falling.
      if (start_fresh) begin
        state             <= ST_CMD;
        flash_csb_core    <= 1'b0;
        req_ready         <= 1'b0;
        bit_cnt           <= 5'(CMD_BITS - 1);
        flash_io0_do_core <= SPI_CMD_READ[7];
        tx_sr             <= {SPI_CMD_READ[6:0], start_addr, 1'b0};
        last_addr         <= start_addr;
      end
    end
  end

endmodule
